// File: rtl/id_display_scan.sv
// Purpose : 4-digit multiplexed common-anode display for the student-ID FSM (AN3=state, AN2/AN1=ID history, AN0=live ID).
// Latency : an/seg/dp are registered, so they reflect scan counter/index/digit values one clock later.
// Backpress: none; the block samples its inputs every clock and never stalls the FSM.
// Optional : define SEG_BLINK_EN to blink the state digit while the FSM sits on its final ID digit (state 8).
module id_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] student_id,
    input  logic [3:0] current_state,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int              CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYC);

    // Parameter sanity: each slot needs its blanking window plus at least two lit cycles.
    if (REFRESH_DIV < BLANK_CYC + 2) begin : g_bad_refresh
        $error("id_display_scan: REFRESH_DIV must be at least BLANK_CYC+2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("id_display_scan: BLINK_DIV must be at least 1");
    end

    // Registered copies of the FSM outputs and the two-deep ID history.
    logic [3:0]    id_q;
    logic [3:0]    state_q;
    logic [3:0]    hist1;
    logic [3:0]    hist2;
    logic          v1;
    logic          v2;

    // Scan timing.
    logic [CW-1:0] slot_cnt;
    logic [1:0]    scan_idx;

    // Digit selection for the slot currently being scanned.
    logic [3:0]    digit;
    logic          digit_blank;
    logic          blink_blank;
    logic          in_blank;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Capture FSM outputs each clock; push the previously shown ID into history on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q    <= 4'h0;
            state_q <= 4'h0;
            hist1   <= 4'h0;
            hist2   <= 4'h0;
            v1      <= 1'b0;
            v2      <= 1'b0;
        end else begin
            id_q    <= student_id;
            state_q <= current_state;
            // Comparing against the registered state catches the 8->0 wrap like any other step;
            // an ID change alone leaves history untouched.
            if (current_state != state_q) begin
                hist2 <= hist1;
                v2    <= v1;
                hist1 <= id_q;
                v1    <= 1'b1;
            end
        end
    end

    // Slot counter and scan index: the index advances only when a slot finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            scan_idx <= 2'd0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

`ifdef SEG_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    // Free-running blink timebase; phase flips every BLINK_DIV clocks and restarts only on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // The state digit goes dark in the off phase while the FSM shows its final ID digit.
    assign blink_blank = !blink_on && (state_q == 4'h8);
`else
    // Without blinking the state digit is always lit.
    assign blink_blank = 1'b0;
`endif

    // The first BLANK_CYC cycles of each slot keep all anodes off so the previous digit cannot ghost.
    assign in_blank = (slot_cnt < BLANK_END);

    // Pick the digit (and whether it is blank) for the slot being scanned.
    always_comb begin
        digit       = id_q;
        digit_blank = 1'b0;
        case (scan_idx)
            2'd0: begin
                digit       = id_q;
                digit_blank = 1'b0;
            end
            2'd1: begin
                digit       = hist1;
                digit_blank = !v1;
            end
            2'd2: begin
                digit       = hist2;
                digit_blank = !v2;
            end
            default: begin
                digit       = state_q;
                digit_blank = blink_blank;
            end
        endcase
    end

    // Register the display drive; a blank digit still drives its anode with all segments off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (in_blank) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << scan_idx);
            seg <= digit_blank ? 7'h7F : hex_to_seg(digit);
            // Decimal point separates the state digit from the ID digits; it follows the blink.
            dp  <= (scan_idx == 2'd3 && !digit_blank) ? 1'b0 : 1'b1;
        end
    end

endmodule

// File: tb/tb_id_display_scan.sv
// Bench for id_display_scan: directed scenarios then random FSM activity, every cycle compared
// against a cycle-count/queue model of the display (small refresh parameters for speed).
module tb_id_display_scan;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BD = 4;

    logic       clk;
    logic       reset;
    logic [3:0] student_id;
    logic [3:0] current_state;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_checks;
    int n_fail;

    // Reference model state.
    logic [6:0] hex_tab [16];
    logic [3:0] m_id;
    logic [3:0] m_state;
    logic [3:0] hq [$];
    int         cyc;

    id_display_scan #(
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC),
        .BLINK_DIV   (BD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .student_id    (student_id),
        .current_state (current_state),
        .seg           (seg),
        .dp            (dp),
        .an            (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_id    = 4'h0;
        m_state = 4'h0;
        hq.delete();
        cyc     = 0;
    endtask

    // One clock: predict the outputs after the coming edge, advance the model, then compare.
    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] dig;
        bit         blank;
        int         pos;
        int         idx;
        pos   = cyc % RD;
        idx   = (cyc / RD) % 4;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        dig   = 4'h0;
        blank = 1'b0;
        if (pos >= BC) begin
            e_an = ~(4'b0001 << idx);
            case (idx)
                0: dig = m_id;
                1: if (hq.size() > 0) dig = hq[0]; else blank = 1'b1;
                2: if (hq.size() > 1) dig = hq[1]; else blank = 1'b1;
                default: begin
                    dig = m_state;
`ifdef SEG_BLINK_EN
                    if (m_state == 4'h8 && ((cyc / BD) % 2 == 1)) blank = 1'b1;
`endif
                    e_dp = blank ? 1'b1 : 1'b0;
                end
            endcase
            e_seg = blank ? 7'h7F : hex_tab[dig];
        end
        if (current_state != m_state) begin
            hq.push_front(m_id);
            if (hq.size() > 2) void'(hq.pop_back());
        end
        m_id    = student_id;
        m_state = current_state;
        cyc++;
        @(posedge clk);
        #1;
        chk("an", {3'b000, an}, {3'b000, e_an});
        chk("seg", seg, e_seg);
        chk("dp", {6'b0, dp}, {6'b0, e_dp});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001;
        hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
        hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
        hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
        hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000;
        hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
        hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001;
        hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;

        clk           = 1'b0;
        reset         = 1'b1;
        student_id    = 4'h0;
        current_state = 4'h0;
        model_reset();

        // Reset state.
        #12;
        chk("rst_an", {3'b000, an}, 7'h0F);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", {6'b0, dp}, 7'h01);
        @(negedge clk);
        reset      = 1'b0;
        student_id = 4'h5;
        model_reset();

        // Mid-slot asynchronous reset takes effect immediately.
        run(5);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_an", {3'b000, an}, 7'h0F);
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_dp", {6'b0, dp}, 7'h01);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // First lit slot appears on the third edge after release.
        run(3);
        chk("first_lit_an", {3'b000, an}, 7'b0001110);

        // Hold id=5, state=0 for more than a full frame.
        run(37);

        // Step state 0->1 and 1->2 with the ID moving along.
        current_state = 4'h1; student_id = 4'h0;
        run(32);
        current_state = 4'h2; student_id = 4'h1;
        run(32);

        // ID change alone does not shift history.
        student_id = 4'h3;
        run(8);
        student_id = 4'h7;
        run(32);

        // 8->0 wrap shifts, then a high state number.
        current_state = 4'h8; student_id = 4'h2;
        run(32);
        current_state = 4'h0; student_id = 4'h5;
        run(32);
        current_state = 4'hE;
        run(32);

        // Final ID digit: state digit blinks only in the blink build.
        current_state = 4'h8;
        run(64);

        // Random FSM activity, including state changes on slot boundaries.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7, 0) == 0) current_state = 4'($urandom_range(15, 0));
            if ($urandom_range(2, 0) == 0) student_id = 4'($urandom_range(15, 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
